// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard stall/flush controller.
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hazard_state_e;

  // Memory-wait counter width: enough to reach the timeout value, never zero bits.
  function automatic int wait_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, taken-branch and data-memory-wait hazards,
// with a memory timeout FSM and saturating stall/flush counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] RdE,
  input  logic                 LoadE,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 MemErr,
  output logic [CNT_W-1:0]     StallCount,
  output logic [CNT_W-1:0]     FlushCount
);

  localparam int WAIT_W     = wait_width(MEM_TIMEOUT);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  hazard_state_e     state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic              mem_err_r;
  logic              miss_s;
  logic              lu_s;
  logic              br_s;
  logic              br_active_s;
  logic              any_stall_s;

  assign miss_s = MemReqM & ~MemReadyM;
  assign lu_s   = LoadE & (RdE != {REG_IDX_W{1'b0}}) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign br_s   = PCSrcE;

  assign wait_nxt_s = wait_cnt_r + WAIT_W'(1);

  // Priority-encoded stall/flush enables; a freeze keeps the branch pending in E.
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    br_active_s = 1'b0;
    if ((state_r == ERR) || miss_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (br_s) begin
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      br_active_s = 1'b1;
    end else if (lu_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
      StallD = 1'b0;
    end
  end

  assign any_stall_s = StallF | StallD | StallE | StallM;

  // Memory-wait tracking; ERR is only left through rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        RUN, WAIT: begin
          if (miss_s) begin
            wait_cnt_r <= wait_nxt_s;
            if (TIMEOUT_EN && (wait_nxt_s == WAIT_W'(MEM_TIMEOUT))) begin
              state_r   <= ERR;
              mem_err_r <= 1'b1;
            end else begin
              state_r   <= WAIT;
              mem_err_r <= 1'b0;
            end
          end else begin
            state_r    <= RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
          end
        end
        ERR: begin
          state_r   <= ERR;
          mem_err_r <= 1'b1;
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= {WAIT_W{1'b0}};
          mem_err_r  <= 1'b0;
        end
      endcase
    end
  end

  assign MemErr = mem_err_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (any_stall_s),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_active_s),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench: three instances (default, short timeout, 3-bit counters)
// share one stimulus stream.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       load, pcsrc, memreq, memready;

  logic        a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_err;
  logic [31:0] a_sc, a_fc;
  logic        b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_err;
  logic [31:0] b_sc, b_fc;
  logic        c_sf, c_sd, c_se, c_sm, c_fd, c_fe, c_err;
  logic [2:0]  c_sc, c_fc;

  logic [5:0] a_ctl, b_ctl;
  assign a_ctl = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe};
  assign b_ctl = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(rs1), .Rs2D(rs2), .RdE(rd), .LoadE(load),
    .PCSrcE(pcsrc), .MemReqM(memreq), .MemReadyM(memready),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm), .FlushD(a_fd), .FlushE(a_fe),
    .MemErr(a_err), .StallCount(a_sc), .FlushCount(a_fc));

  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_to (
    .clk(clk), .rst_n(rst_n), .Rs1D(rs1), .Rs2D(rs2), .RdE(rd), .LoadE(load),
    .PCSrcE(pcsrc), .MemReqM(memreq), .MemReadyM(memready),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm), .FlushD(b_fd), .FlushE(b_fe),
    .MemErr(b_err), .StallCount(b_sc), .FlushCount(b_fc));

  hazard_stall_unit #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .Rs1D(rs1), .Rs2D(rs2), .RdE(rd), .LoadE(load),
    .PCSrcE(pcsrc), .MemReqM(memreq), .MemReadyM(memready),
    .StallF(c_sf), .StallD(c_sd), .StallE(c_se), .StallM(c_sm), .FlushD(c_fd), .FlushE(c_fe),
    .MemErr(c_err), .StallCount(c_sc), .FlushCount(c_fc));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    load = 1'b0; pcsrc = 1'b0; memreq = 1'b0; memready = 1'b0;
  endtask

  // Called just after a falling edge; pulses reset well clear of any rising edge.
  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Control vector order: StallF StallD StallE StallM FlushD FlushE
  initial begin
    set_idle();
    rst_n = 1'b0;
    #3;
    chk("reset_stallcount", a_sc, 32'd0);
    chk("reset_flushcount", a_fc, 32'd0);
    chk("reset_memerr", a_err, 1'b0);
    chk("reset_ctl", a_ctl, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on Rs1D
    @(negedge clk);
    load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd2;
    #1 chk("lu_ctl", a_ctl, 6'b110001);
    @(negedge clk);
    chk("lu_stallcount", a_sc, 32'd1);
    // Same pattern with x0 as destination: no hazard
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1 chk("lu_x0_ctl", a_ctl, 6'b000000);
    @(negedge clk);
    chk("lu_x0_stallcount", a_sc, 32'd1);

    // Branch beats load-use on Rs2D
    pcsrc = 1'b1; load = 1'b1; rd = 5'd7; rs2 = 5'd7; rs1 = 5'd1;
    #1 chk("br_lu_ctl", a_ctl, 6'b000011);
    @(negedge clk);
    chk("br_flushcount", a_fc, 32'd1);
    chk("br_stallcount", a_sc, 32'd1);
    set_idle();

    // Memory wait: three not-ready cycles, then ready in the same cycle as the request
    @(negedge clk);
    do_reset();
    memreq = 1'b1; memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("miss_ctl", a_ctl, 6'b111100);
      @(negedge clk);
    end
    memready = 1'b1;
    #1 chk("ready_ctl", a_ctl, 6'b000000);
    chk("miss_stallcount", a_sc, 32'd3);
    @(negedge clk);
    chk("ready_stallcount", a_sc, 32'd3);
    chk("ready_to_memerr", b_err, 1'b0);
    // Second burst: the short-timeout instance must have restarted its wait count
    memready = 1'b0;
    repeat (3) @(negedge clk);
    memready = 1'b1;
    @(negedge clk);
    chk("burst2_to_memerr", b_err, 1'b0);
    chk("burst2_stallcount", a_sc, 32'd6);
    set_idle();

    // Timeout on the MEM_TIMEOUT=4 instance
    @(negedge clk);
    do_reset();
    memreq = 1'b1; memready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("to_memerr_edge", b_err, (i == 4) ? 1'b1 : 1'b0);
    end
    chk("to_long_memerr", a_err, 1'b0);
    memready = 1'b1;
    #1 chk("err_ctl", b_ctl, 6'b111100);
    chk("err_ready_long_ctl", a_ctl, 6'b000000);
    @(negedge clk);
    chk("err_sticky", b_err, 1'b1);
    chk("err_stallcount", b_sc, 32'd5);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_memerr", b_err, 1'b0);
    chk("async_rst_ctl", b_ctl, 6'b000000);
    chk("async_rst_stallcount", b_sc, 32'd0);
    rst_n = 1'b1;
    set_idle();

    // Saturation on the 3-bit counter instance
    @(negedge clk);
    do_reset();
    load = 1'b1; rd = 5'd5; rs1 = 5'd5;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("sat_stallcount", c_sc, (i < 7) ? 3'(i) : 3'd7);
    end
    chk("nosat_stallcount", a_sc, 32'd10);
    @(negedge clk);
    chk("sat_hold", c_sc, 3'd7);
    set_idle();

    // Miss + branch + load-use together: freeze, then branch once memory is ready
    @(negedge clk);
    do_reset();
    memreq = 1'b1; memready = 1'b0; pcsrc = 1'b1; load = 1'b1; rd = 5'd5; rs1 = 5'd5;
    #1 chk("triple_ctl", a_ctl, 6'b111100);
    @(negedge clk);
    chk("triple_flushcount", a_fc, 32'd0);
    chk("triple_stallcount", a_sc, 32'd1);
    memready = 1'b1;
    #1 chk("release_ctl", a_ctl, 6'b000011);
    @(negedge clk);
    chk("release_flushcount", a_fc, 32'd1);
    chk("release_stallcount", a_sc, 32'd1);
    set_idle();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage pipeline: it covers the hazards that operand forwarding cannot resolve. It detects load-use dependencies, taken branches/jumps and multi-cycle data-memory waits, and drives per-stage stall and flush enables. It sits beside the forwarding logic in the hazard path and adds a timeout FSM plus saturating stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready memory cycles before error; 0 disables the timeout
- CNT_W, 32: width of the performance counters

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; asynchronous, active-low
- Rs1D  in  5  source register 1 of the instruction in Decode
- Rs2D  in  5  source register 2 of the instruction in Decode
- RdE  in  5  destination register of the instruction in Execute
- LoadE  in  1  instruction in Execute is a load
- PCSrcE  in  1  taken branch or jump resolved in Execute
- MemReqM  in  1  Memory stage is issuing a data-memory access
- MemReadyM  in  1  data memory completes the access this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold the IF/ID register
- StallE  out  1  hold the ID/EX register
- StallM  out  1  hold the EX/MEM register
- FlushD  out  1  clear the IF/ID register
- FlushE  out  1  clear the ID/EX register
- MemErr  out  1  sticky memory timeout error
- StallCount  out  CNT_W  cycles with any stall asserted, saturating
- FlushCount  out  CNT_W  taken-branch flush events, saturating

## Operation
- Conditions, evaluated combinationally each cycle:
  - miss = MemReqM & ~MemReadyM
  - lu = LoadE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D))
  - br = PCSrcE
- Output priority, highest first:
  - state ERR: StallF/D/E/M = 1, flushes 0
  - miss: StallF/D/E/M = 1, FlushD/E = 0. The pipeline freezes. PCSrcE stays held by the frozen E stage, so the branch is taken after the freeze ends.
  - br: FlushD = FlushE = 1, all stalls 0. Br beats lu because the dependent instruction in D is discarded.
  - lu: StallF = StallD = 1, FlushE = 1 (one-cycle bubble), StallE/M = 0
  - otherwise all stall and flush outputs are 0
- FSM states: RUN, WAIT, ERR.
  - RUN/WAIT, miss at the edge: wait_cnt <= wait_cnt+1 and state <= WAIT. If MEM_TIMEOUT != 0 and wait_cnt+1 == MEM_TIMEOUT, state <= ERR instead.
  - RUN/WAIT, no miss: state <= RUN and wait_cnt <= 0.
  - ERR is absorbing until rst_n is asserted. MemErr = (state == ERR).
- Counters:
  - StallCount increments on each edge where any Stall output is 1, including ERR cycles.
  - FlushCount increments on each edge where the br rule is the active rule.
  - Both hold at all-ones once saturated.
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits wide, minimum 1.

## Timing
- All stall and flush outputs are combinational from the current state and inputs, with zero latency.
- MemErr and the counters are registered and change one edge after the causing cycle.
- Reset (rst_n low, asynchronous): state = RUN, wait_cnt = 0, MemErr = 0, StallCount = 0, FlushCount = 0. Stall and flush outputs then follow the RUN rules on the live inputs.
- Reset asserted mid-WAIT or in ERR clears to RUN immediately, with no clock edge needed.
- MemReadyM high in the same cycle as MemReqM is not a miss: no stall and no WAIT entry.
- miss, br and lu in the same cycle: freeze only. Neither counter's flush path fires; StallCount increments.

## Structure
- hazard_pkg holds the state enum (RUN, WAIT, ERR) and the register-index width constant (5).
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated twice for the two counters.

## Test plan
- Load-use: LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle; StallCount goes 0 -> 1. Same stimulus with RdE=0 -> no stall.
- Branch with lu present: PCSrcE=1, LoadE=1, RdE=Rs2D=7 -> FlushD=FlushE=1, StallF=0; FlushCount goes 0 -> 1 and StallCount unchanged.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high, MEM_TIMEOUT=16 -> all four stalls high for exactly 3 cycles; StallCount = 3; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, MemReadyM held low -> MemErr rises after the 4th edge and stays high after MemReadyM goes high. Async rst_n pulse clears MemErr without a clock edge.
- Saturation: CNT_W=3, 10 consecutive lu cycles -> StallCount reads 7 and holds.
- Miss + br + lu simultaneously -> freeze only, FlushD=0; once MemReadyM goes high with PCSrcE still held, FlushD=FlushE=1 and FlushCount increments.
